// File: rtl/mips_to_riscv_xlate_stream_if.sv
// Handshake bundle for the streaming MIPS-to-RV32I translator: MIPS words in, RV32I words out.
interface mips_to_riscv_xlate_stream_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_last;
   logic        out_illegal;

   modport master (
      output in_valid, in_instr, out_ready,
      input  in_ready, out_valid, out_instr, out_last, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, out_ready,
      output in_ready, out_valid, out_instr, out_last, out_illegal
   );
endinterface

// File: rtl/mips_to_riscv_xlate_stream.sv
// Streaming MIPS32-to-RV32I translator: each accepted MIPS word expands to 1..3 RV32I words
// that are queued in an output FIFO.
module mips_to_riscv_xlate_stream #(
   parameter int unsigned DEPTH        = 4,
   parameter logic [4:0]  TMP_REG      = 5'd1,
   parameter logic [4:0]  LINK_REG     = 5'd31,
   parameter logic [31:0] ILLEGAL_WORD = 32'h0000_0000,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        flush,
   mips_to_riscv_xlate_stream_if.slave bus,
   output logic                        busy,
   output logic [CNT_W-1:0]            illegal_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [6:0] OPC_OP   = 7'b0110011;
   localparam logic [6:0] OPC_IMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD = 7'b0000011;
   localparam logic [6:0] OPC_JALR = 7'b1100111;

   typedef enum logic [0:0] {StIdle, StEmit} state_e;

   function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, OPC_OP};
   endfunction

   function automatic logic [31:0] i_op(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] s_op(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction

   // imm holds offset bits [12:1]; bit 0 is always zero.
   function automatic logic [31:0] b_op(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] u_op(input logic [19:0] imm, input logic [4:0] rd);
      return {imm, rd, 7'b0110111};
   endfunction

   state_e            state_q, state_d;
   logic [1:0]        step_q, step_d;
   logic [31:0]       word_q, word_d;
   logic [AW:0]       wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       instr_mem [DEPTH];
   logic              last_mem  [DEPTH];
   logic              ill_mem   [DEPTH];

   logic [31:0] dec_op [3];
   logic [1:0]  dec_n;
   logic        dec_ill;
   logic        full, empty, last_step, push, pop, accept;

   // Field extraction and immediate helpers for the latched word
   logic [5:0]  opc, fn;
   logic [4:0]  rs, rt, rd, sh;
   logic [15:0] imm;
   logic [31:0] sx, va, bsum;
   logic [19:0] hi_a, hi_m;
   logic [2:0]  alu_f3, mem_f3;
   logic        fit_s, fit_a, tmp_hit;

   always_comb begin
      opc     = word_q[31:26];
      rs      = word_q[25:21];
      rt      = word_q[20:16];
      rd      = word_q[15:11];
      sh      = word_q[10:6];
      fn      = word_q[5:0];
      imm     = word_q[15:0];
      sx      = {{16{imm[15]}}, imm};
      va      = opc[2] ? {16'h0000, imm} : sx;
      fit_s   = (imm[15:11] == 5'h00) || (imm[15:11] == 5'h1f);
      fit_a   = opc[2] ? (imm[15:11] == 5'h00) : fit_s;
      // (v + 0x800) >> 12 rounds hi so that the sign-extended lo lands back on v
      hi_a    = va[31:12] + {19'b0, va[11]};
      hi_m    = sx[31:12] + {19'b0, sx[11]};
      bsum    = sx + 32'd1;
      tmp_hit = (rs == TMP_REG) || (rt == TMP_REG);
      mem_f3  = (opc[2:0] == 3'b011) ? 3'b010 : opc[2:0];
      case (opc[2:0])
         3'b010:  alu_f3 = 3'b010;
         3'b011:  alu_f3 = 3'b011;
         3'b100:  alu_f3 = 3'b111;
         3'b101:  alu_f3 = 3'b110;
         3'b110:  alu_f3 = 3'b100;
         default: alu_f3 = 3'b000;
      endcase
   end

   always_comb begin
      dec_op[0] = ILLEGAL_WORD;
      dec_op[1] = ILLEGAL_WORD;
      dec_op[2] = ILLEGAL_WORD;
      dec_n     = 2'd1;
      dec_ill   = 1'b0;
      case (opc)
         6'h00: begin
            case (fn)
               6'h00: dec_op[0] = i_op({7'b0000000, sh}, rt, 3'b001, rd, OPC_IMM);
               6'h02: dec_op[0] = i_op({7'b0000000, sh}, rt, 3'b101, rd, OPC_IMM);
               6'h03: dec_op[0] = i_op({7'b0100000, sh}, rt, 3'b101, rd, OPC_IMM);
               6'h04: dec_op[0] = r_op(7'b0000000, rs, rt, 3'b001, rd);
               6'h06: dec_op[0] = r_op(7'b0000000, rs, rt, 3'b101, rd);
               6'h07: dec_op[0] = r_op(7'b0100000, rs, rt, 3'b101, rd);
               6'h08: dec_op[0] = i_op(12'h000, rs, 3'b000, 5'd0, OPC_JALR);
               6'h09: dec_op[0] = i_op(12'h000, rs, 3'b000, (rd == 5'd0) ? LINK_REG : rd,
                                       OPC_JALR);
               6'h0c: dec_op[0] = 32'h0000_0073;
               6'h0d: dec_op[0] = 32'h0010_0073;
               6'h20, 6'h21: dec_op[0] = r_op(7'b0000000, rt, rs, 3'b000, rd);
               6'h22, 6'h23: dec_op[0] = r_op(7'b0100000, rt, rs, 3'b000, rd);
               6'h24: dec_op[0] = r_op(7'b0000000, rt, rs, 3'b111, rd);
               6'h25: dec_op[0] = r_op(7'b0000000, rt, rs, 3'b110, rd);
               6'h26: dec_op[0] = r_op(7'b0000000, rt, rs, 3'b100, rd);
               6'h27: begin
                  dec_n     = 2'd2;
                  dec_op[0] = r_op(7'b0000000, rt, rs, 3'b110, rd);
                  dec_op[1] = i_op(12'hfff, rd, 3'b100, rd, OPC_IMM);
               end
               6'h2a: dec_op[0] = r_op(7'b0000000, rt, rs, 3'b010, rd);
               6'h2b: dec_op[0] = r_op(7'b0000000, rt, rs, 3'b011, rd);
               default: dec_ill = 1'b1;
            endcase
         end
         6'h04, 6'h05: begin
            // Reach is +-4 KiB once the MIPS word offset becomes a byte offset from this PC
            if ((bsum[31:10] == 22'h0) || (bsum[31:10] == 22'h3fffff)) begin
               dec_op[0] = b_op({bsum[10:0], 1'b0}, rt, rs, {2'b00, opc[0]});
            end else begin
               dec_ill = 1'b1;
            end
         end
         6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: begin
            if (fit_a) begin
               dec_op[0] = i_op(va[11:0], rs, alu_f3, rt, OPC_IMM);
            end else if (tmp_hit) begin
               dec_ill = 1'b1;
            end else begin
               dec_n     = 2'd3;
               dec_op[0] = u_op(hi_a, TMP_REG);
               dec_op[1] = i_op(va[11:0], TMP_REG, 3'b000, TMP_REG, OPC_IMM);
               dec_op[2] = r_op(7'b0000000, TMP_REG, rs, alu_f3, rt);
            end
         end
         6'h0f: dec_op[0] = u_op({imm, 4'b0000}, rt);
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
            if (fit_s) begin
               dec_op[0] = i_op(sx[11:0], rs, mem_f3, rt, OPC_LOAD);
            end else if (tmp_hit) begin
               dec_ill = 1'b1;
            end else begin
               dec_n     = 2'd3;
               dec_op[0] = u_op(hi_m, TMP_REG);
               dec_op[1] = r_op(7'b0000000, rs, TMP_REG, 3'b000, TMP_REG);
               dec_op[2] = i_op(sx[11:0], TMP_REG, mem_f3, rt, OPC_LOAD);
            end
         end
         6'h28, 6'h29, 6'h2b: begin
            if (fit_s) begin
               dec_op[0] = s_op(sx[11:0], rt, rs, mem_f3);
            end else if (tmp_hit) begin
               dec_ill = 1'b1;
            end else begin
               dec_n     = 2'd3;
               dec_op[0] = u_op(hi_m, TMP_REG);
               dec_op[1] = r_op(7'b0000000, rs, TMP_REG, 3'b000, TMP_REG);
               dec_op[2] = s_op(sx[11:0], rt, TMP_REG, mem_f3);
            end
         end
         default: dec_ill = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         step_q  <= 2'd0;
         word_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         word_q  <= word_d;
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      word_d  = word_q;
      if (accept) begin
         state_d = StEmit;
         step_d  = 2'd0;
         word_d  = bus.in_instr;
      end else if (push) begin
         if (last_step) state_d = StIdle;
         else           step_d  = step_q + 2'd1;
      end
      if (flush) state_d = StIdle;
   end

   always_comb begin
      empty         = (wr_ptr_q == rd_ptr_q);
      full          = ((wr_ptr_q - rd_ptr_q) == (AW+1)'(DEPTH));
      last_step     = (step_q == (dec_n - 2'd1));
      push          = (state_q == StEmit) && !full && !flush;
      bus.in_ready  = !flush && ((state_q == StIdle) ||
                                 ((state_q == StEmit) && last_step && !full));
      accept        = bus.in_ready && bus.in_valid;
      bus.out_valid = !empty;
      pop           = !empty && bus.out_ready;
      bus.out_instr   = instr_mem[rd_ptr_q[AW-1:0]];
      bus.out_last    = last_mem[rd_ptr_q[AW-1:0]];
      bus.out_illegal = ill_mem[rd_ptr_q[AW-1:0]];
      busy          = (state_q == StEmit) || !empty;
      illegal_cnt   = cnt_q;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr_q[AW-1:0]] <= dec_op[step_q];
         last_mem[wr_ptr_q[AW-1:0]]  <= last_step;
         ill_mem[wr_ptr_q[AW-1:0]]   <= dec_ill;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push && dec_ill && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_mips_to_riscv_xlate_stream.sv
// Directed bench for the streaming translator; expected words go through a scoreboard queue.
module tb_mips_to_riscv_xlate_stream;

   logic       clk;
   logic       reset;
   logic       flush;
   logic       busy;
   logic [1:0] illegal_cnt;
   int         tests;
   int         fails;
   logic [33:0] exp_q[$];

   mips_to_riscv_xlate_stream_if bus ();

   mips_to_riscv_xlate_stream #(
      .DEPTH        (4),
      .TMP_REG      (5'd1),
      .LINK_REG     (5'd31),
      .ILLEGAL_WORD (32'h0000_0000),
      .CNT_W        (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .bus         (bus),
      .busy        (busy),
      .illegal_cnt (illegal_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h, required %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] instr, input logic last, input logic ill);
      exp_q.push_back({ill, last, instr});
   endtask

   // Called at the falling edge: a handshake seen now completes at the next rising edge
   task automatic mon();
      logic [33:0] got;
      logic [33:0] want;
      if (bus.out_valid && bus.out_ready) begin
         got = {bus.out_illegal, bus.out_last, bus.out_instr};
         tests++;
         assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL spurious_out: got %h, required no output", got);
         end
         if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            chk("out_word", {30'b0, got}, {30'b0, want});
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w);
      bit ok;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_instr = w;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         mon();
         ok = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      chk("accept", {63'b0, ok}, 64'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_idle(input string tag, input logic [1:0] cnt);
      @(negedge clk);
      chk({tag, "_out_valid"}, {63'b0, bus.out_valid}, 64'd0);
      chk({tag, "_in_ready"}, {63'b0, bus.in_ready}, 64'd1);
      chk({tag, "_busy"}, {63'b0, busy}, 64'd0);
      chk({tag, "_cnt"}, {62'b0, illegal_cnt}, {62'b0, cnt});
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] ADD1 = 32'h014B_4820;
   localparam logic [31:0] RV1  = 32'h00B5_04B3;
   localparam logic [31:0] ADD2 = 32'h0085_1820;
   localparam logic [31:0] RV2  = 32'h0052_01B3;
   localparam logic [31:0] ORI  = 32'h3528_8001;

   task automatic exp_ori();
      push_exp(32'h0000_80B7, 1'b0, 1'b0);
      push_exp(32'h0010_8093, 1'b0, 1'b0);
      push_exp(32'h0014_E433, 1'b1, 1'b0);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      flush = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = 32'h0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_idle("reset", 2'd0);

      // Single add, with first-word latency
      push_exp(RV1, 1'b1, 1'b0);
      send(ADD1);
      @(negedge clk);
      chk("lat_e0", {63'b0, bus.out_valid}, 64'd0);
      chk("busy_emit", {63'b0, busy}, 64'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("lat_e1", {63'b0, bus.out_valid}, 64'd1);
      mon();
      @(posedge clk);
      #1;
      drain();

      push_exp(32'hFFF4_8413, 1'b1, 1'b0);
      send(32'h2128_FFFF);
      exp_ori();
      send(ORI);
      drain();

      // Back-pressure fills the 4-entry FIFO
      bus.out_ready = 1'b0;
      exp_ori();
      send(ORI);
      push_exp(RV1, 1'b1, 1'b0);
      send(ADD1);
      push_exp(RV2, 1'b1, 1'b0);
      send(ADD2);
      tick();
      tick();
      @(negedge clk);
      chk("full_in_ready", {63'b0, bus.in_ready}, 64'd0);
      chk("full_out_valid", {63'b0, bus.out_valid}, 64'd1);
      chk("full_busy", {63'b0, busy}, 64'd1);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      drain();

      // Illegal words and counter saturation at 2'b11
      push_exp(32'h0, 1'b1, 1'b1);
      send(32'hFC00_0000);
      drain();
      check_idle("ill1", 2'd1);
      push_exp(32'h0, 1'b1, 1'b1);
      send(32'h0800_0000);
      drain();
      check_idle("ill2", 2'd2);
      push_exp(32'h0, 1'b1, 1'b1);
      send(32'h0C00_0000);
      push_exp(32'h0, 1'b1, 1'b1);
      send(32'hFC00_0000);
      drain();
      check_idle("ill_sat", 2'd3);

      // Assorted mappings streamed back to back
      push_exp(32'h0041_9113, 1'b1, 1'b0);
      send(32'h0003_1100);
      push_exp(32'h0000_0073, 1'b1, 1'b0);
      send(32'h0000_000C);
      push_exp(32'h0002_0FE7, 1'b1, 1'b0);
      send(32'h0080_0009);
      push_exp(32'h0041_E133, 1'b0, 1'b0);
      push_exp(32'hFFF1_4113, 1'b1, 1'b0);
      send(32'h0064_1027);
      push_exp(32'h0000_10B7, 1'b0, 1'b0);
      push_exp(32'h0090_80B3, 1'b0, 1'b0);
      push_exp(32'h2340_A403, 1'b1, 1'b0);
      send(32'h8D28_1234);
      push_exp(32'h0052_0863, 1'b1, 1'b0);
      send(32'h1085_0003);
      push_exp(32'h0, 1'b1, 1'b1);
      send(32'h1085_0400);
      drain();

      // Flush one cycle after the first ORI word is pushed
      bus.out_ready = 1'b0;
      send(ORI);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_idle("flush", 2'd3);
      bus.out_ready = 1'b1;
      repeat (6) tick();
      push_exp(RV2, 1'b1, 1'b0);
      send(ADD2);
      drain();

      // Reset mid-expansion also clears the illegal counter
      bus.out_ready = 1'b0;
      send(ORI);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle("rst_mid", 2'd0);
      bus.out_ready = 1'b1;
      repeat (6) tick();
      push_exp(RV1, 1'b1, 1'b0);
      send(ADD1);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
